// File: rtl/mips_pkg.sv
// Shared opcode/funct encodings, controller states and ALU operation codes
// for the multi-cycle MIPS core.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;

  function automatic logic op_valid(input logic [5:0] op, input logic [5:0] funct);
    case (op)
      OP_RTYPE: return funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
      OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // beq compares through the subtractor's zero flag; every non-R-type
  // instruction that reaches EXEC otherwise needs an address/immediate add.
  function automatic alu_op_t alu_sel(input logic [5:0] op, input logic [5:0] funct);
    if (op == OP_BEQ) return ALU_SUB;
    if (op != OP_RTYPE) return ALU_ADD;
    case (funct)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mips_alu.sv
// Shared combinational ALU: add/sub/and/or/signed slt plus zero flag.
// Zero latency; no flow control.
module mips_alu
  import mips_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  alu_op_t             i_op,
  input  logic [DATA_W-1:0]   i_a,
  input  logic [DATA_W-1:0]   i_b,
  output logic [DATA_W-1:0]   o_y,
  output logic                o_zero
);

  always_comb begin
    o_y = '0;
    case (i_op)
      ALU_ADD: o_y = i_a + i_b;
      ALU_SUB: o_y = i_a - i_b;
      ALU_AND: o_y = i_a & i_b;
      ALU_OR:  o_y = i_a | i_b;
      ALU_SLT: o_y = {{(DATA_W-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      default: o_y = '0;
    endcase
  end

  assign o_zero = (o_y == '0);

endmodule

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS core: one instruction per 3-5 cycles, retire pulse on completion.
// No backpressure; HALT is absorbing until reset, with error flagging faults.
module mips_multicycle_core
  import mips_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int IMEM_BYTES = 256,
  parameter int DMEM_WORDS = 64,
  parameter int REG_COUNT  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        instruction_mem [IMEM_BYTES],
  output logic [DATA_W-1:0] alu_result,
  output logic [31:0]       pc,
  output logic              retire,
  output logic              halted,
  output logic              error
);

  localparam int IA_W = (IMEM_BYTES > 1) ? $clog2(IMEM_BYTES) : 1;
  localparam int DA_W = $clog2(DMEM_WORDS);

  state_t              r_state, w_state_nxt;
  logic [31:0]         r_pc, r_ir, w_pc_nxt, w_word;
  logic [DATA_W-1:0]   r_a, r_b, r_alu, r_mdr;
  logic                r_retire, r_halted, r_error;
  logic [DATA_W-1:0]   r_regs [REG_COUNT];
  logic [DATA_W-1:0]   r_dmem [DMEM_WORDS];

  logic                w_ir_ld, w_pc_inc, w_pc_ld, w_dec, w_alu_ld, w_mem_wr, w_mdr_ld;
  logic                w_reg_wr, w_retire, w_set_halt, w_set_err, w_fetch_bad, w_alu_zero;
  logic [5:0]          w_op, w_funct;
  logic [4:0]          w_rs, w_rt, w_rd, w_dest;
  logic [DATA_W-1:0]   w_sext, w_alu_b, w_alu_y, w_tgt, w_wb_dat;
  logic [IA_W-1:0]     w_ia;
  logic [DA_W-1:0]     w_didx;

  assign w_op    = r_ir[31:26];
  assign w_rs    = r_ir[25:21];
  assign w_rt    = r_ir[20:16];
  assign w_rd    = r_ir[15:11];
  assign w_funct = r_ir[5:0];
  assign w_sext  = {{(DATA_W-16){r_ir[15]}}, r_ir[15:0]};
  assign w_tgt   = DATA_W'(r_pc) + (w_sext << 2);

  // 33-bit compare so a pc near 2^32 cannot wrap past the bound.
  assign w_fetch_bad = (({1'b0, r_pc} + 33'd3) >= 33'(IMEM_BYTES)) || (r_pc[1:0] != 2'b00);
  assign w_ia   = r_pc[IA_W-1:0];
  assign w_word = {instruction_mem[w_ia], instruction_mem[w_ia + IA_W'(1)],
                   instruction_mem[w_ia + IA_W'(2)], instruction_mem[w_ia + IA_W'(3)]};

  assign w_alu_b  = (w_op == OP_RTYPE || w_op == OP_BEQ) ? r_b : w_sext;
  assign w_didx   = r_alu[DA_W+1:2];
  assign w_dest   = (w_op == OP_RTYPE) ? w_rd : w_rt;
  assign w_wb_dat = (w_op == OP_LW) ? r_mdr : r_alu;

  mips_alu #(.DATA_W(DATA_W)) u_alu (
    .i_op   (alu_sel(w_op, w_funct)),
    .i_a    (r_a),
    .i_b    (w_alu_b),
    .o_y    (w_alu_y),
    .o_zero (w_alu_zero)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_ir_ld = 1'b0; w_pc_inc = 1'b0; w_pc_ld = 1'b0; w_pc_nxt = r_pc;
    w_dec = 1'b0; w_alu_ld = 1'b0; w_mem_wr = 1'b0; w_mdr_ld = 1'b0;
    w_reg_wr = 1'b0; w_retire = 1'b0; w_set_halt = 1'b0; w_set_err = 1'b0;
    case (r_state)
      FETCH: begin
        if (w_fetch_bad) begin
          w_state_nxt = HALT; w_set_halt = 1'b1; w_set_err = 1'b1;
        end else begin
          w_ir_ld = 1'b1; w_pc_inc = 1'b1; w_state_nxt = DECODE;
        end
      end
      DECODE: begin
        w_dec = 1'b1;
        if (w_op == OP_HALT) begin
          w_state_nxt = HALT; w_set_halt = 1'b1;
        end else if (!op_valid(w_op, w_funct)) begin
          w_state_nxt = HALT; w_set_halt = 1'b1; w_set_err = 1'b1;
        end else begin
          w_state_nxt = EXEC;
        end
      end
      EXEC: begin
        // Jumps resolve here rather than in DECODE to give the 3-cycle jump.
        case (w_op)
          OP_J: begin
            w_pc_ld = 1'b1; w_pc_nxt = {r_pc[31:28], r_ir[25:0], 2'b00};
            w_retire = 1'b1; w_state_nxt = FETCH;
          end
          OP_BEQ: begin
            w_pc_ld = w_alu_zero; w_pc_nxt = r_alu[31:0];
            w_retire = 1'b1; w_state_nxt = FETCH;
          end
          OP_LW, OP_SW: begin w_alu_ld = 1'b1; w_state_nxt = MEM; end
          default:      begin w_alu_ld = 1'b1; w_state_nxt = WB;  end
        endcase
      end
      MEM: begin
        if (r_alu[1:0] != 2'b00) begin
          w_state_nxt = HALT; w_set_halt = 1'b1; w_set_err = 1'b1;
        end else if (w_op == OP_SW) begin
          w_mem_wr = 1'b1; w_retire = 1'b1; w_state_nxt = FETCH;
        end else begin
          w_mdr_ld = 1'b1; w_state_nxt = WB;
        end
      end
      WB: begin
        w_reg_wr = (w_dest != 5'd0); w_retire = 1'b1; w_state_nxt = FETCH;
      end
      default: w_state_nxt = HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= FETCH; r_pc <= '0; r_ir <= '0; r_a <= '0; r_b <= '0;
      r_alu <= '0; r_mdr <= '0; r_retire <= 1'b0; r_halted <= 1'b0; r_error <= 1'b0;
      for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= '0;
      for (int i = 0; i < DMEM_WORDS; i++) r_dmem[i] <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_retire <= w_retire;
      if (w_ir_ld)  r_ir <= w_word;
      if (w_pc_inc) r_pc <= r_pc + 32'd4;
      if (w_pc_ld)  r_pc <= w_pc_nxt;
      if (w_dec) begin
        r_a <= r_regs[w_rs]; r_b <= r_regs[w_rt]; r_alu <= w_tgt;
      end
      if (w_alu_ld) r_alu <= w_alu_y;
      if (w_mem_wr) r_dmem[w_didx] <= r_b;
      if (w_mdr_ld) r_mdr <= r_dmem[w_didx];
      if (w_reg_wr) r_regs[w_dest] <= w_wb_dat;
      if (w_set_halt) begin
        r_halted <= 1'b1; r_error <= w_set_err;
      end
    end
  end

  assign alu_result = r_alu;
  assign pc         = r_pc;
  assign retire     = r_retire;
  assign halted     = r_halted;
  assign error      = r_error;

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed-program bench for mips_multicycle_core: default, 16-byte IMEM and 64-bit instances.
module tb_mips_multicycle_core;
  import mips_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Main instance: default parameters.
  logic        rst_a;
  logic [7:0]  mem_a [256];
  logic [31:0] alu_a, pc_a;
  logic        ret_a, halt_a, err_a;

  mips_multicycle_core #(.DATA_W(32), .IMEM_BYTES(256), .DMEM_WORDS(64), .REG_COUNT(32)) dut_a (
    .clk(clk), .reset(rst_a), .instruction_mem(mem_a), .alu_result(alu_a),
    .pc(pc_a), .retire(ret_a), .halted(halt_a), .error(err_a)
  );

  // Tiny IMEM instance for running off the end.
  logic        rst_s;
  logic [7:0]  mem_s [16];
  logic [31:0] alu_s, pc_s;
  logic        ret_s, halt_s, err_s;

  mips_multicycle_core #(.DATA_W(32), .IMEM_BYTES(16), .DMEM_WORDS(64), .REG_COUNT(32)) dut_s (
    .clk(clk), .reset(rst_s), .instruction_mem(mem_s), .alu_result(alu_s),
    .pc(pc_s), .retire(ret_s), .halted(halt_s), .error(err_s)
  );

  // 64-bit datapath instance.
  logic        rst_w;
  logic [7:0]  mem_w [256];
  logic [63:0] alu_w;
  logic [31:0] pc_w;
  logic        ret_w, halt_w, err_w;

  mips_multicycle_core #(.DATA_W(64), .IMEM_BYTES(256), .DMEM_WORDS(64), .REG_COUNT(32)) dut_w (
    .clk(clk), .reset(rst_w), .instruction_mem(mem_w), .alu_result(alu_w),
    .pc(pc_w), .retire(ret_w), .halted(halt_w), .error(err_w)
  );

  int          ret_cyc[$];
  logic [31:0] ret_alu[$];

  task automatic put_a(input int addr, input logic [31:0] w);
    mem_a[addr] = w[31:24]; mem_a[addr+1] = w[23:16]; mem_a[addr+2] = w[15:8]; mem_a[addr+3] = w[7:0];
  endtask

  task automatic clear_a();
    for (int i = 0; i < 256; i++) mem_a[i] = 8'h00;
  endtask

  // Holds reset for two edges, checks the reset state, then releases.
  task automatic reset_a(input string tag);
    rst_a = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check({tag, ".rst_pc"}, pc_a, 0);
    check({tag, ".rst_state"}, dut_a.r_state, FETCH);
    check({tag, ".rst_halted"}, {ret_a, halt_a, err_a, alu_a}, 0);
    rst_a = 1'b1;
  endtask

  task automatic run_a(input string tag, input int budget);
    int cyc = 0;
    ret_cyc.delete();
    ret_alu.delete();
    while (!halt_a && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
      if (ret_a) begin
        ret_cyc.push_back(cyc);
        ret_alu.push_back(alu_a);
      end
    end
    check({tag, ".halted"}, halt_a, 1);
  endtask

  task automatic load_memtrip();
    clear_a();
    put_a(0, 32'h2003000C);   // addi r3, r0, 12
    put_a(4, 32'hAC030004);   // sw r3, 4(r0)
    put_a(8, 32'h8C040004);   // lw r4, 4(r0)
    put_a(12, 32'hFC000000);  // halt
  endtask

  initial begin
    int cyc;
    rst_a = 1'b0; rst_s = 1'b0; rst_w = 1'b0;

    for (int i = 0; i < 16; i++) mem_s[i] = 8'h00;
    {mem_s[0], mem_s[1], mem_s[2], mem_s[3]}     = 32'h20010001;
    {mem_s[4], mem_s[5], mem_s[6], mem_s[7]}     = 32'h20020002;
    {mem_s[8], mem_s[9], mem_s[10], mem_s[11]}   = 32'h20030003;
    {mem_s[12], mem_s[13], mem_s[14], mem_s[15]} = 32'h20040004;
    for (int i = 0; i < 256; i++) mem_w[i] = 8'h00;
    {mem_w[0], mem_w[1], mem_w[2], mem_w[3]}     = 32'h2001FFFF;  // addi r1, r0, -1
    {mem_w[4], mem_w[5], mem_w[6], mem_w[7]}     = 32'h00211020;  // add r2, r1, r1
    {mem_w[8], mem_w[9], mem_w[10], mem_w[11]}   = 32'h0020182A;  // slt r3, r1, r0
    {mem_w[12], mem_w[13], mem_w[14], mem_w[15]} = 32'hFC000000;
    repeat (2) @(posedge clk);
    #1;
    rst_s = 1'b1; rst_w = 1'b1;

    // ALU chain
    clear_a();
    put_a(0, 32'h20010005); put_a(4, 32'h20020007); put_a(8, 32'h00221820); put_a(12, 32'hFC000000);
    reset_a("alu");
    run_a("alu", 200);
    check("alu.r3", dut_a.r_regs[3], 12);
    check("alu.retires", ret_cyc.size(), 3);
    if (ret_cyc.size() == 3) begin
      check("alu.addi_cycles", ret_cyc[1] - ret_cyc[0], 4);
      check("alu.add_cycles", ret_cyc[2] - ret_cyc[1], 4);
      check("alu.result_after_add", ret_alu[2], 12);
    end
    check("alu.error", err_a, 0);
    check("alu.pc", pc_a, 16);

    // Memory round trip
    load_memtrip();
    reset_a("mem");
    run_a("mem", 200);
    check("mem.r4", dut_a.r_regs[4], 12);
    check("mem.dmem1", dut_a.r_dmem[1], 12);
    check("mem.retires", ret_cyc.size(), 3);
    if (ret_cyc.size() == 3) begin
      check("mem.sw_cycles", ret_cyc[1] - ret_cyc[0], 4);
      check("mem.lw_cycles", ret_cyc[2] - ret_cyc[1], 5);
    end
    check("mem.error", err_a, 0);

    // Taken branch skips addi r5
    clear_a();
    put_a(0, 32'h20010005); put_a(4, 32'h10210001); put_a(8, 32'h20050001); put_a(12, 32'hFC000000);
    reset_a("beq");
    run_a("beq", 200);
    check("beq.r5", dut_a.r_regs[5], 0);
    check("beq.r1", dut_a.r_regs[1], 5);
    check("beq.retires", ret_cyc.size(), 2);
    if (ret_cyc.size() == 2) check("beq.cycles", ret_cyc[1] - ret_cyc[0], 3);
    check("beq.pc", pc_a, 16);
    check("beq.error", err_a, 0);

    // Undefined opcode
    clear_a();
    put_a(0, 32'h7C000000);
    reset_a("badop");
    run_a("badop", 50);
    check("badop.error", err_a, 1);
    check("badop.pc", pc_a, 4);

    // Misaligned load
    clear_a();
    put_a(0, 32'h8C010002);
    reset_a("misal");
    run_a("misal", 50);
    check("misal.error", err_a, 1);
    check("misal.r1", dut_a.r_regs[1], 0);

    // Reset while lw sits in MEM
    load_memtrip();
    reset_a("rstmid");
    cyc = 0;
    ret_cyc.delete();
    while (ret_cyc.size() < 2 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (ret_a) ret_cyc.push_back(cyc);
    end
    check("rstmid.sw_retired", ret_cyc.size(), 2);
    repeat (3) @(posedge clk);
    #1;
    check("rstmid.in_mem", dut_a.r_state, MEM);
    rst_a = 1'b0;
    @(posedge clk); #1;
    check("rstmid.pc", pc_a, 0);
    check("rstmid.state", dut_a.r_state, FETCH);
    check("rstmid.r3", dut_a.r_regs[3], 0);
    check("rstmid.dmem1", dut_a.r_dmem[1], 0);
    check("rstmid.outs", {ret_a, halt_a, err_a, alu_a}, 0);
    @(posedge clk); #1;
    check("rstmid.no_wb_r4", dut_a.r_regs[4], 0);
    rst_a = 1'b1;

    // Small and wide instances have long since stopped; bound the wait anyway.
    cyc = 0;
    while (!(halt_s && halt_w) && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("small.halted", halt_s, 1);
    check("small.error", err_s, 1);
    check("small.pc", pc_s, 16);
    check("small.r4", dut_s.r_regs[4], 4);
    check("wide.halted", halt_w, 1);
    check("wide.error", err_w, 0);
    check("wide.r1", dut_w.r_regs[1], 64'hFFFF_FFFF_FFFF_FFFF);
    check("wide.r2", dut_w.r_regs[2], 64'hFFFF_FFFF_FFFF_FFFE);
    check("wide.r3", dut_w.r_regs[3], 64'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
